// File: rtl/traffic_phase_scheduler.sv
// Two-street intersection phase sequencer: green/yellow/all-red timing, sensor
// gap-out/max-out arbitration, manual force holds and a BCD countdown for the display.
module traffic_phase_scheduler #(
  parameter int TICK_DIV  = 50,
  parameter int MIN_GREEN = 5,
  parameter int MAX_GREEN = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       CLK,
  input  logic       nR,
  input  logic       A_Traffic,
  input  logic       B_Traffic,
  input  logic       A_Force,
  input  logic       B_Force,
  output logic [2:0] A_Light,
  output logic [2:0] B_Light,
  output logic [7:0] Remain,
  output logic       Blank,
  output logic [2:0] Phase
);

  typedef enum logic [2:0] {
    AG  = 3'd0,
    AY  = 3'd1,
    RAB = 3'd2,
    BG  = 3'd3,
    BY  = 3'd4,
    RBA = 3'd5,
    FA  = 3'd6,
    FB  = 3'd7
  } phase_t;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [7:0] BCD_GREEN  = {4'(MAX_GREEN / 10), 4'(MAX_GREEN % 10)};
  localparam logic [7:0] BCD_YELLOW = {4'(YELLOW_T / 10), 4'(YELLOW_T % 10)};
  localparam logic [7:0] BCD_ALLRED = {4'(ALLRED_T / 10), 4'(ALLRED_T % 10)};
  localparam logic [2:0] L_RED = 3'b100;
  localparam logic [2:0] L_YEL = 3'b010;
  localparam logic [2:0] L_GRN = 3'b001;

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) bcd_dec = {v[7:4] - 4'd1, 4'd9};
    else                bcd_dec = {v[7:4], v[3:0] - 4'd1};
  endfunction

  phase_t        r_state;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_remain;
  logic [6:0]    r_elapsed;
  logic          r_frc_a;
  logic          r_frc_b;
  logic [2:0]    r_a_light;
  logic [2:0]    r_b_light;
  logic          r_blank;

  phase_t        w_nxt;
  logic          w_frc_a_nxt;
  logic          w_frc_b_nxt;
  logic          w_tick;
  logic          w_end;
  logic          w_gap_a;
  logic          w_gap_b;
  logic          w_entry;
  logic          w_green;
  logic [7:0]    w_len;
  logic [7:0]    w_remain_nxt;
  logic [6:0]    w_elapsed_nxt;
  logic [PW-1:0] w_presc_nxt;
  logic [2:0]    w_a_light_nxt;
  logic [2:0]    w_b_light_nxt;

  // A force request on either street cancels the other; both together cancel both.
  assign w_frc_a_nxt = ~B_Force & (A_Force | r_frc_a);
  assign w_frc_b_nxt = ~A_Force & (B_Force | r_frc_b);

  assign w_tick  = (r_presc == PRESC_LAST);
  assign w_end   = w_tick && (r_remain == 8'h01);
  assign w_gap_a = w_tick && (r_elapsed >= 7'(MIN_GREEN)) && !A_Traffic && B_Traffic;
  assign w_gap_b = w_tick && (r_elapsed >= 7'(MIN_GREEN)) && !B_Traffic && A_Traffic;
  assign w_green = (r_state == AG) || (r_state == BG);

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      AG:  if (w_frc_a_nxt) w_nxt = FA;
           else if (w_frc_b_nxt || w_gap_a || (w_end && B_Traffic)) w_nxt = AY;
      BG:  if (w_frc_b_nxt) w_nxt = FB;
           else if (w_frc_a_nxt || w_gap_b || (w_end && A_Traffic)) w_nxt = BY;
      AY:  if (w_end) w_nxt = RAB;
      RAB: if (w_end) w_nxt = w_frc_b_nxt ? FB : BG;
      BY:  if (w_end) w_nxt = RBA;
      RBA: if (w_end) w_nxt = w_frc_a_nxt ? FA : AG;
      FA:  if (!w_frc_a_nxt) w_nxt = w_frc_b_nxt ? AY : AG;
      FB:  if (!w_frc_b_nxt) w_nxt = w_frc_a_nxt ? BY : BG;
      default: w_nxt = RBA;
    endcase
  end

  assign w_entry = (w_nxt != r_state);

  always_comb begin
    w_len         = 8'h00;
    w_a_light_nxt = L_RED;
    w_b_light_nxt = L_RED;
    case (w_nxt)
      AG, FA:   begin w_len = (w_nxt == AG) ? BCD_GREEN : 8'h00; w_a_light_nxt = L_GRN; end
      BG, FB:   begin w_len = (w_nxt == BG) ? BCD_GREEN : 8'h00; w_b_light_nxt = L_GRN; end
      AY:       begin w_len = BCD_YELLOW; w_a_light_nxt = L_YEL; end
      BY:       begin w_len = BCD_YELLOW; w_b_light_nxt = L_YEL; end
      RAB, RBA: w_len = BCD_ALLRED;
      default:  w_len = 8'h00;
    endcase
  end

  // Timer is frozen in the force holds; only green can reach a tick at 01
  // without leaving, which is the rest case that reloads the maximum green.
  always_comb begin
    w_remain_nxt  = r_remain;
    w_elapsed_nxt = r_elapsed;
    w_presc_nxt   = w_tick ? '0 : r_presc + PW'(1);
    if (w_entry) begin
      w_remain_nxt  = w_len;
      w_elapsed_nxt = 7'd0;
      w_presc_nxt   = '0;
    end else if (w_tick && (r_state != FA) && (r_state != FB)) begin
      w_remain_nxt = (r_remain == 8'h01) ? BCD_GREEN : bcd_dec(r_remain);
      if (w_green && (r_elapsed < 7'd99)) w_elapsed_nxt = r_elapsed + 7'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nR) begin
      r_state   <= RBA;
      r_presc   <= '0;
      r_remain  <= BCD_ALLRED;
      r_elapsed <= 7'd0;
      r_frc_a   <= 1'b0;
      r_frc_b   <= 1'b0;
      r_a_light <= L_RED;
      r_b_light <= L_RED;
      r_blank   <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_presc   <= w_presc_nxt;
      r_remain  <= w_remain_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_frc_a   <= w_frc_a_nxt;
      r_frc_b   <= w_frc_b_nxt;
      r_a_light <= w_a_light_nxt;
      r_b_light <= w_b_light_nxt;
      r_blank   <= (w_nxt == FA) || (w_nxt == FB);
    end
  end

  assign A_Light = r_a_light;
  assign B_Light = r_b_light;
  assign Remain  = r_remain;
  assign Blank   = r_blank;
  assign Phase   = r_state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Randomized bench for traffic_phase_scheduler against an integer-seconds phase model.
module tb_traffic_phase_scheduler;

  localparam int TICK_DIV  = 2;
  localparam int MIN_GREEN = 3;
  localparam int MAX_GREEN = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int N_CYCLES  = 4000;
  localparam int W         = 18;

  logic       CLK;
  logic       nR;
  logic       A_Traffic, B_Traffic, A_Force, B_Force;
  logic [2:0] A_Light, B_Light, Phase;
  logic [7:0] Remain;
  logic       Blank;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  int m_ph, m_rem, m_el, m_pre;
  bit m_fa, m_fb;

  traffic_phase_scheduler #(
    .TICK_DIV(TICK_DIV), .MIN_GREEN(MIN_GREEN), .MAX_GREEN(MAX_GREEN),
    .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T)
  ) dut (
    .CLK(CLK), .nR(nR),
    .A_Traffic(A_Traffic), .B_Traffic(B_Traffic),
    .A_Force(A_Force), .B_Force(B_Force),
    .A_Light(A_Light), .B_Light(B_Light),
    .Remain(Remain), .Blank(Blank), .Phase(Phase)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int phase_len(input int ph);
    case (ph)
      0, 3:    phase_len = MAX_GREEN;
      1, 4:    phase_len = YELLOW_T;
      2, 5:    phase_len = ALLRED_T;
      default: phase_len = 0;
    endcase
  endfunction

  // Phase numbering: 0 AG,1 AY,2 RAB,3 BG,4 BY,5 RBA,6 FA,7 FB
  function automatic logic [W-1:0] expected_outputs();
    logic [2:0] a, b;
    logic [7:0] bcd;
    a = 3'b100;
    b = 3'b100;
    if (m_ph == 0 || m_ph == 6) a = 3'b001;
    if (m_ph == 1)              a = 3'b010;
    if (m_ph == 3 || m_ph == 7) b = 3'b001;
    if (m_ph == 4)              b = 3'b010;
    bcd = {4'(m_rem / 10), 4'(m_rem % 10)};
    expected_outputs = {3'(m_ph), a, b, bcd, (m_ph >= 6)};
  endfunction

  task automatic model_step(input bit rst_n, input bit at, input bit bt, input bit af, input bit bf);
    int np;
    bit nfa, nfb, tick, done, gap_a, gap_b;
    if (!rst_n) begin
      m_ph = 5; m_rem = ALLRED_T; m_el = 0; m_pre = 0; m_fa = 0; m_fb = 0;
    end else begin
      nfa   = bf ? 1'b0 : (af ? 1'b1 : m_fa);
      nfb   = af ? 1'b0 : (bf ? 1'b1 : m_fb);
      tick  = (m_pre == TICK_DIV - 1);
      done  = tick && (m_rem == 1);
      gap_a = tick && (m_el >= MIN_GREEN) && !at && bt;
      gap_b = tick && (m_el >= MIN_GREEN) && !bt && at;
      np = m_ph;
      case (m_ph)
        0: if (nfa) np = 6; else if (nfb || gap_a || (done && bt)) np = 1;
        3: if (nfb) np = 7; else if (nfa || gap_b || (done && at)) np = 4;
        1: if (done) np = 2;
        2: if (done) np = nfb ? 7 : 3;
        4: if (done) np = 5;
        5: if (done) np = nfa ? 6 : 0;
        6: if (!nfa) np = nfb ? 1 : 0;
        default: if (!nfb) np = nfa ? 4 : 3;
      endcase
      if (np != m_ph) begin
        m_pre = 0; m_el = 0; m_rem = phase_len(np);
      end else begin
        if (m_ph < 6 && tick) begin
          m_rem = (m_rem == 1) ? MAX_GREEN : m_rem - 1;
          if ((m_ph == 0 || m_ph == 3) && m_el < 99) m_el++;
        end
        m_pre = tick ? 0 : m_pre + 1;
      end
      m_fa = nfa; m_fb = nfb; m_ph = np;
    end
    exp_q.push_back(expected_outputs());
  endtask

  // driver: choose inputs for the coming edge
  task automatic drive_cycle(input int cyc);
    A_Force = 1'b0;
    B_Force = 1'b0;
    nR      = 1'b1;
    if (cyc < 2) begin
      nR = 1'b0; A_Traffic = 1'b1; B_Traffic = 1'b0;
    end else if (cyc < 60) begin
      A_Traffic = 1'b1; B_Traffic = 1'b0;
    end else if (cyc < 120) begin
      A_Traffic = 1'b0; B_Traffic = 1'b1;
    end else if (cyc < 320) begin
      A_Traffic = 1'b1; B_Traffic = 1'b1;
      if (cyc == 200) A_Force = 1'b1;
      if (cyc == 240) begin A_Force = 1'b1; B_Force = 1'b1; end
      if (cyc == 280) B_Force = 1'b1;
      if (cyc == 300) begin A_Force = 1'b1; B_Force = 1'b1; end
    end else begin
      if ($urandom_range(0, 7) == 0) A_Traffic = ~A_Traffic;
      if ($urandom_range(0, 7) == 0) B_Traffic = ~B_Traffic;
      case ($urandom_range(0, 149))
        0, 1, 2: A_Force = 1'b1;
        3, 4, 5: B_Force = 1'b1;
        6, 7:    begin A_Force = 1'b1; B_Force = 1'b1; end
        default: ;
      endcase
      if ($urandom_range(0, 499) == 0) nR = 1'b0;
    end
  endtask

  // scoreboard
  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("phase",   32'(Phase),   32'(e[17:15]));
    check("a_light", 32'(A_Light), 32'(e[14:12]));
    check("b_light", 32'(B_Light), 32'(e[11:9]));
    check("remain",  32'(Remain),  32'(e[8:1]));
    check("blank",   32'(Blank),   32'(e[0]));
    check("overlap", 32'((A_Light != 3'b100) && (B_Light != 3'b100)), 32'd0);
  endtask

  initial begin
    A_Traffic = 1'b0; B_Traffic = 1'b0; A_Force = 1'b0; B_Force = 1'b0; nR = 1'b0;
    m_ph = 5; m_rem = ALLRED_T; m_el = 0; m_pre = 0; m_fa = 0; m_fb = 0;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      drive_cycle(cyc);
      model_step(nR, A_Traffic, B_Traffic, A_Force, B_Force);
      @(negedge CLK);
      compare_outputs();
    end
    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
